cordic_rr_scheduler: RTL

//  Time-shares one cordic_polar_to_rect rotator among NUM_REQ requesters, e.g. the a/b coefficient

---
 rtl/cordic_rr_scheduler.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/cordic_rr_scheduler.sv
// cordic_rr_scheduler
// Round-robin arbiter that time-shares a single CORDIC rotator among NUM_REQ
// requesters. A request is accepted with a valid/ready handshake, the operands
// are issued to the CORDIC with a one-cycle strobe, and the result is returned
// to the granted requester as a one-cycle tagged pulse.
//
// Optional feature macro: CORDIC_SCHED_TIMEOUT_EN
//   When defined, a watchdog counts WAIT cycles. After TIMEOUT_CYCLES without
//   done, it pulses cordic_reset for one cycle and then answers with zero data
//   and rsp_err = 1. When undefined, WAIT waits indefinitely and rsp_err = 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate; grant first valid requester from rr_ptr upward
// ST_ISSUE | cordic_stb high for one cycle with the latched operands
// ST_WAIT  | hold operands, wait for cordic_done (or watchdog)
// ST_RESP  | rsp_valid[g] for one cycle, advance rr_ptr past g

module cordic_rr_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int XY_BITS        = 16,
  parameter int PHASE_BITS     = 16,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*XY_BITS-1:0]    req_xval,
  input  logic [NUM_REQ*PHASE_BITS-1:0] req_phase,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [XY_BITS-1:0]            rsp_xval,
  output logic [XY_BITS-1:0]            rsp_yval,
  output logic                          rsp_err,
  output logic                          cordic_reset,
  output logic                          cordic_stb,
  output logic [XY_BITS-1:0]            cordic_xval,
  output logic [XY_BITS-1:0]            cordic_yval,
  output logic [PHASE_BITS-1:0]         cordic_phase,
  input  logic                          cordic_done,
  input  logic [XY_BITS-1:0]            cordic_xout,
  input  logic [XY_BITS-1:0]            cordic_yout,
  output logic                          sched_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("cordic_rr_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        gnt_q, gnt_d;
  logic [XY_BITS-1:0]      xval_q, xval_d;
  logic [PHASE_BITS-1:0]   phase_q, phase_d;
  logic [XY_BITS-1:0]      rx_q, rx_d;
  logic [XY_BITS-1:0]      ry_q, ry_d;

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wd_q, wd_d;
  logic                    err_q, err_d;
`endif

  logic                    gnt_found;
  logic [PTR_W-1:0]        gnt_idx;
  logic [PTR_W:0]          cand_sum;

  // Rotating priority search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
      end
      if (!gnt_found && req_valid[cand_sum[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_sum[PTR_W-1:0];
      end
    end
  end

  // Next-state and handshake logic for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    xval_d    = xval_q;
    phase_d   = phase_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    req_ready = '0;
    rsp_valid = '0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    wd_d      = 1'b0;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          gnt_d   = gnt_idx;
          xval_d  = req_xval[gnt_idx*XY_BITS +: XY_BITS];
          phase_d = req_phase[gnt_idx*PHASE_BITS +: PHASE_BITS];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef CORDIC_SCHED_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
`ifdef CORDIC_SCHED_TIMEOUT_EN
        // The watchdog cycle wins over a late done: the rotator is being reset.
        if (wd_q) begin
          rx_d    = '0;
          ry_d    = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (cordic_done) begin
          rx_d    = cordic_xout;
          ry_d    = cordic_yout;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            wd_d = 1'b1;
          end
        end
`else
        if (cordic_done) begin
          rx_d    = cordic_xout;
          ry_d    = cordic_yout;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        rr_ptr_d = (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      xval_q   <= '0;
      phase_q  <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
      cnt_q    <= '0;
      wd_q     <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      xval_q   <= xval_d;
      phase_q  <= phase_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
`ifdef CORDIC_SCHED_TIMEOUT_EN
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  assign cordic_stb   = (state_q == ST_ISSUE);
  assign cordic_xval  = xval_q;
  assign cordic_yval  = '0;
  assign cordic_phase = phase_q;
  assign rsp_xval     = rx_q;
  assign rsp_yval     = ry_q;
  assign sched_busy   = (state_q != ST_IDLE);

`ifdef CORDIC_SCHED_TIMEOUT_EN
  assign rsp_err      = err_q;
  assign cordic_reset = rst | wd_q;
`else
  assign rsp_err      = 1'b0;
  assign cordic_reset = rst;
`endif

endmodule
